// File: rtl/instr_fetch.sv
// instr_fetch -- single-stage instruction fetch unit with a one-entry
// instruction register (ir) feeding decode.
//
// Parameters
//   RESET_PC      fetch address loaded on reset
//   HALT_ON_ZERO  when 1, the word 16'h0000 halts fetch instead of being issued
//
// Ports
//   clk        clock, all state updates on its rising edge
//   rst_n      asynchronous active-low reset
//   en         fetch enable
//   addr       instruction memory read address (straight from the fetch PC)
//   instr      combinational memory data for addr
//   ir         instruction register to decode
//   ir_pc      address ir was fetched from
//   ir_valid   ir holds an instruction not yet taken by decode
//   ir_ready   decode accepts ir this cycle
//   br_taken   redirect request (highest priority, also leaves HALT)
//   br_target  redirect address
//   halted     fetch is stopped on a halt word
module instr_fetch #(
  parameter logic [3:0] RESET_PC     = 4'd0,
  parameter int         HALT_ON_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [3:0]  addr,
  input  logic [15:0] instr,
  output logic [15:0] ir,
  output logic [3:0]  ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        br_taken,
  input  logic [3:0]  br_target,
  output logic        halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state, state_n;
  logic [3:0]  pc, pc_n;
  logic [15:0] ir_n;
  logic [3:0]  ir_pc_n;
  logic        ir_valid_n;

  logic xfer, cap, is_halt;

  // ir may be refilled when empty or when decode drains it on this same edge.
  assign xfer    = ir_valid & ir_ready;
  assign cap     = (state == RUN) & en & ~br_taken & (~ir_valid | ir_ready);
  assign is_halt = (HALT_ON_ZERO != 0) && (instr == 16'h0000);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    if (br_taken) begin
      // Flush: a transfer on this edge still happened from decode's view,
      // the register is simply emptied and fetch restarts at the target.
      pc_n       = br_target;
      ir_valid_n = 1'b0;
      state_n    = RUN;
    end else if (cap && is_halt) begin
      // The halt word is never issued; pc parks on its address.
      state_n    = HALT;
      ir_valid_n = ir_valid & ~ir_ready;
    end else if (cap) begin
      ir_n       = instr;
      ir_pc_n    = pc;
      ir_valid_n = 1'b1;
      pc_n       = pc + 4'd1;
    end else if (xfer) begin
      ir_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc       <= RESET_PC;
      ir       <= 16'h0000;
      ir_pc    <= 4'd0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
    end
  end

  assign addr   = pc;
  assign halted = (state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances share the control inputs, one halting
// on zero words and one not, each reading its own program array.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, ir_ready = 1'b0, br_taken = 1'b0;
  logic [3:0]  br_target = 4'd0;
  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  logic [3:0]  addr0, addr1, ir_pc0, ir_pc1;
  logic [15:0] instr0, instr1, ir0, ir1;
  logic        ir_valid0, ir_valid1, halted0, halted1;

  int checks = 0, failures = 0;

  // Reference state: what fetch should look like, per instance.
  int          mpc   [2];
  logic [15:0] mir   [2];
  int          mirpc [2];
  bit          mv    [2];
  bit          mh    [2];
  bit          hoz   [2];

  always #5 clk = ~clk;

  assign instr0 = mem0[addr0];
  assign instr1 = mem1[addr1];

  instr_fetch #(.RESET_PC(4'd0), .HALT_ON_ZERO(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .addr(addr0), .instr(instr0),
    .ir(ir0), .ir_pc(ir_pc0), .ir_valid(ir_valid0), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_target(br_target), .halted(halted0));

  instr_fetch #(.RESET_PC(4'd0), .HALT_ON_ZERO(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .addr(addr1), .instr(instr1),
    .ir(ir1), .ir_pc(ir_pc1), .ir_valid(ir_valid1), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_target(br_target), .halted(halted1));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] memrd(input int k, input int a);
    return (k == 0) ? mem0[a] : mem1[a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mpc[k] = 0; mir[k] = 16'h0000; mirpc[k] = 0; mv[k] = 0; mh[k] = 0;
    end
  endtask

  // One clock edge worth of behaviour, from the current inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [15:0] w;
      if (br_taken) begin
        mpc[k] = int'(br_target); mv[k] = 0; mh[k] = 0;
      end else if (!mh[k] && en && (!mv[k] || ir_ready)) begin
        w = memrd(k, mpc[k]);
        if (hoz[k] && w == 16'h0000) begin
          mh[k] = 1;
          mv[k] = mv[k] && !ir_ready;
        end else begin
          mir[k] = w; mirpc[k] = mpc[k]; mv[k] = 1;
          mpc[k] = (mpc[k] + 1) % 16;
        end
      end else if (mv[k] && ir_ready) begin
        mv[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("d0.addr",     {12'd0, addr0},     16'(mpc[0]));
    chk("d0.ir",       ir0,                mir[0]);
    chk("d0.ir_pc",    {12'd0, ir_pc0},    16'(mirpc[0]));
    chk("d0.ir_valid", {15'd0, ir_valid0}, {15'd0, mv[0]});
    chk("d0.halted",   {15'd0, halted0},   {15'd0, mh[0]});
    chk("d1.addr",     {12'd0, addr1},     16'(mpc[1]));
    chk("d1.ir",       ir1,                mir[1]);
    chk("d1.ir_pc",    {12'd0, ir_pc1},    16'(mirpc[1]));
    chk("d1.ir_valid", {15'd0, ir_valid1}, {15'd0, mv[1]});
    chk("d1.halted",   {15'd0, halted1},   {15'd0, mh[1]});
  endtask

  // Inputs are driven at posedge+1; the edge is taken and outputs sampled 1ns later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset asserted between edges; outputs must change without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst.ir",     ir0,                16'h0000);
    chk("rst.halted", {15'd0, halted0},   16'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] prog [5];
    prog = '{16'hA00A, 16'h5005, 16'h6006, 16'h0A50, 16'h06A0};
    hoz[0] = 1; hoz[1] = 0;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = (i < 5) ? prog[i] : 16'h0000;
      mem1[i] = (i == 15) ? 16'h1234 : 16'h0000;
    end
    model_reset();
    @(posedge clk); #1;
    en = 1'b1; ir_ready = 1'b1;
    do_reset();

    // Straight-line program runs into the halt word at 5.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("prog.ir", ir0, prog[i]);
      chk("prog.ir_pc", {12'd0, ir_pc0}, 16'(i));
    end
    tick();
    chk("halt.halted", {15'd0, halted0}, 16'd1);
    chk("halt.addr", {12'd0, addr0}, 16'd5);
    chk("halt.ir_valid", {15'd0, ir_valid0}, 16'd0);
    tick(); tick();
    chk("halt.stay_addr", {12'd0, addr0}, 16'd5);
    chk("halt.stay", {15'd0, halted0}, 16'd1);

    // Redirect out of HALT.
    br_taken = 1'b1; br_target = 4'd2;
    tick();
    chk("br.halted", {15'd0, halted0}, 16'd0);
    chk("br.ir_valid", {15'd0, ir_valid0}, 16'd0);
    chk("br.addr", {12'd0, addr0}, 16'd2);
    br_taken = 1'b0;
    tick();
    chk("br.ir", ir0, 16'h6006);
    chk("br.ir_pc", {12'd0, ir_pc0}, 16'd2);

    // Transfer and redirect on the same edge.
    br_taken = 1'b1; br_target = 4'd3;
    tick();
    chk("brx.ir_valid", {15'd0, ir_valid0}, 16'd0);
    chk("brx.addr", {12'd0, addr0}, 16'd3);
    chk("brx.ir_kept", ir0, 16'h6006);
    br_taken = 1'b0;
    tick();
    chk("brx.ir", ir0, 16'h0A50);
    chk("brx.ir_pc", {12'd0, ir_pc0}, 16'd3);

    // Async reset while holding a valid instruction at addr 3.
    br_taken = 1'b1; br_target = 4'd2;
    tick();
    br_taken = 1'b0;
    tick();
    chk("ar.pre_addr", {12'd0, addr0}, 16'd3);
    chk("ar.pre_valid", {15'd0, ir_valid0}, 16'd1);
    do_reset();
    chk("ar.addr", {12'd0, addr0}, 16'd0);
    chk("ar.ir_valid", {15'd0, ir_valid0}, 16'd0);

    // Backpressure holds ir and addr.
    tick();
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.ir", ir0, 16'hA00A);
      chk("bp.ir_pc", {12'd0, ir_pc0}, 16'd0);
      chk("bp.ir_valid", {15'd0, ir_valid0}, 16'd1);
      chk("bp.addr", {12'd0, addr0}, 16'd1);
    end
    ir_ready = 1'b1;
    tick();
    chk("bp.next", ir0, 16'h5005);
    chk("bp.next_pc", {12'd0, ir_pc0}, 16'd1);

    // Zero words issued as ordinary instructions; pc wraps 15 -> 0.
    br_taken = 1'b1; br_target = 4'd14;
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap.ir_pc", {12'd0, ir_pc1}, 16'((14 + i) % 16));
      chk("wrap.ir", ir1, (i == 1) ? 16'h1234 : 16'h0000);
      chk("wrap.halted", {15'd0, halted1}, 16'd0);
    end

    // Randomized traffic against the reference.
    for (int n = 0; n < 400; n++) begin
      en        = ($urandom_range(3) != 0);
      ir_ready  = ($urandom_range(4) > 1);
      br_taken  = ($urandom_range(11) == 0);
      br_target = 4'($urandom_range(15));
      if ($urandom_range(3) == 0) begin
        int a;
        a = $urandom_range(15);
        mem0[a] = ($urandom_range(1) == 0) ? 16'h0000 : 16'($urandom);
        mem1[a] = ($urandom_range(1) == 0) ? 16'h0000 : 16'($urandom);
      end
      if ($urandom_range(99) == 0) do_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 4'd0: fetch address loaded on reset.
REQ-002 The module SHALL have parameter HALT_ON_ZERO, default 1: when 1, instruction word 16'h0000 is a halt word.
REQ-003 The module SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port en, input, 1: fetch enable.
REQ-006 The module SHALL have port addr, output, 4: read address to instruction memory, equal to the fetch PC register (no combinational path from inputs).
REQ-007 The module SHALL have port instr, input, 16: combinational instruction memory data for addr, valid in the same cycle.
REQ-008 The module SHALL have port ir, output, 16: instruction register to decode.
REQ-009 The module SHALL have port ir_pc, output, 4: address from which ir was fetched.
REQ-010 The module SHALL have port ir_valid, output, 1: ir holds an undelivered instruction.
REQ-011 The module SHALL have port ir_ready, input, 1: decode accepts ir this cycle.
REQ-012 The module SHALL have port br_taken, input, 1: redirect request.
REQ-013 The module SHALL have port br_target, input, 4: redirect address.
REQ-014 The module SHALL have port halted, output, 1: high in state HALT.

Function
REQ-015 The state machine SHALL have exactly two states, RUN and HALT; halted = (state == HALT).
REQ-016 Transfer: an instruction SHALL be delivered when ir_valid=1 and ir_ready=1 on a clock edge.
REQ-017 Capture condition: state RUN, en=1, br_taken=0, and (ir_valid=0 or ir_ready=1).
REQ-018 On capture of a non-halt word: ir<=instr, ir_pc<=addr, ir_valid<=1, fetch PC<=addr+1 modulo 16 (15 wraps to 0).
REQ-019 Latency SHALL be one cycle: a word presented on instr at edge N is visible on ir after edge N.
REQ-020 Capture condition met with HALT_ON_ZERO=1 and instr=16'h0000: ir and ir_pc unchanged, fetch PC unchanged, state<=HALT, ir_valid<=ir_valid & ~ir_ready.
REQ-021 No capture with ir_valid=1 and ir_ready=1: ir_valid<=0.
REQ-022 No capture with ir_valid=1 and ir_ready=0: ir, ir_pc, ir_valid, fetch PC held (backpressure).
REQ-023 en=0: no capture; REQ-021/REQ-022 still apply, so a pending ir still drains.
REQ-024 br_taken=1 in either state SHALL take priority over everything: fetch PC<=br_target, ir_valid<=0 (flush; any simultaneous transfer is still counted by decode), state<=RUN; ir and ir_pc unchanged.
REQ-025 HALT SHALL be left only by br_taken or reset; in HALT, addr stays at the halt word's address.
REQ-026 HALT_ON_ZERO=0: 16'h0000 SHALL be captured as an ordinary instruction.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, set fetch PC (and addr)=RESET_PC, ir=16'h0000, ir_pc=4'd0, ir_valid=0, state=RUN, halted=0.
REQ-028 The first capture SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-029 Memory program 0:A00A, 1:5005, 2:6006, 3:0A50, 4:06A0, 5-15:0000; reset, en=1, ir_ready=1 -> ir = A00A/5005/6006/0A50/06A0 with ir_pc 0..4 after edges 1..5; after edge 6 halted=1, addr=5, ir_valid=0.
REQ-030 Same program, ir_ready=0 from edge 2 for 3 cycles -> ir=A00A, ir_pc=0, ir_valid=1, addr=1 held; after ir_ready returns high, 5005 follows one cycle later.
REQ-031 While halted at addr=5, br_taken=1 with br_target=2 for one cycle -> halted=0, ir_valid=0, addr=2; next edge ir=6006, ir_pc=2.
REQ-032 HALT_ON_ZERO=0, all words 0000 except 15:1234 -> ir_pc sequence 14, 15, 0, 1; ir=1234 when ir_pc=15; halted never asserts.
REQ-033 ir_valid=1 with ir_ready=1 and br_taken=1 (target 3) on the same edge -> ir_valid=0, addr=3, no new capture that edge; next edge ir=0A50, ir_pc=3.
REQ-034 rst_n pulled low between clock edges while ir_valid=1 and addr=3 -> addr=0, ir_valid=0, ir=0000, halted=0 before the next edge.
